// File: rtl/queue_calc_ctrl.sv
// queue_calc_ctrl: sequencer for a queue-based arithmetic evaluator.
// Operands are pushed onto an external queue. An operator combines the two
// head entries and appends the result at the back of the queue. A finished
// expression is reported from the queue head. Any error drains the queue and
// reports an error code.
// Optional feature macro: QUEUE_CALC_MUL_EN (adds MUL through a registered
// product and a one-cycle MULW state; without it MUL is a bad operator).
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_RUN    | accept tokens, drive push / pop-pair commands
// S_MULW   | apply the registered product to the queue (MUL builds only)
// S_RESULT | present queue head as the result, pop it on handshake
// S_FLUSH  | drain the queue after an error, one pop per cycle
// S_REPORT | present the error code until handshake
// S_SKIP   | drop the rest of the failed expression up to its last token
module queue_calc_ctrl #(
  parameter int DEPTH = 5,
  parameter int W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_is_op,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic [1:0]     q_opcode,
  output logic [W-1:0]   q_back,
  input  logic [2*W-1:0] q_top,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_data,
  output logic           res_err,
  output logic [2:0]     res_code
);

  // Occupancy counter needs at least two bits so it can be compared with 2.
  localparam int CW = ($clog2(DEPTH + 1) < 2) ? 2 : $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_HOLD = 2'b01;
  localparam logic [1:0] OP_PAIR = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_OVF   = 3'd1;
  localparam logic [2:0] E_UNF   = 3'd2;
  localparam logic [2:0] E_BADOP = 3'd3;
  localparam logic [2:0] E_END   = 3'd4;

  typedef enum logic [2:0] {
    S_RUN, S_MULW, S_RESULT, S_FLUSH, S_REPORT, S_SKIP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    code, code_nxt;
  logic          skip, skip_nxt;   // erroring token lacked in_last

  logic [W-1:0]  entry0, entry1, sum, diff;

  assign entry0 = q_top[2*W-1:W];
  assign entry1 = q_top[W-1:0];
  assign sum    = entry0 + entry1;
  assign diff   = entry0 - entry1;

`ifdef QUEUE_CALC_MUL_EN
  logic [W-1:0]  mul_q, mul_nxt;
  logic          last_q, last_nxt;  // MUL token carried in_last
`endif

  // State, occupancy and error bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_RUN;
      cnt    <= '0;
      code   <= E_NONE;
      skip   <= 1'b0;
`ifdef QUEUE_CALC_MUL_EN
      mul_q  <= '0;
      last_q <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      code   <= code_nxt;
      skip   <= skip_nxt;
`ifdef QUEUE_CALC_MUL_EN
      mul_q  <= mul_nxt;
      last_q <= last_nxt;
`endif
    end
  end

  // Next-state, queue command and result outputs; the queue command is
  // combinational so the queue updates on the same edge as the accept.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code;
    skip_nxt  = skip;
    in_ready  = 1'b0;
    q_opcode  = OP_HOLD;
    q_back    = '0;
    res_valid = 1'b0;
    res_data  = '0;
    res_err   = 1'b0;
    res_code  = E_NONE;
`ifdef QUEUE_CALC_MUL_EN
    mul_nxt   = mul_q;
    last_nxt  = last_q;
`endif

    case (state)
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!in_is_op) begin
            if (cnt == FULL) begin
              code_nxt  = E_OVF;
              skip_nxt  = !in_last;
              state_nxt = S_FLUSH;
            end else begin
              q_opcode = OP_PUSH;
              q_back   = in_data;
              cnt_nxt  = cnt + 1'b1;
            end
          end else begin
            case (in_data[1:0])
              2'd0, 2'd1: begin
                if (cnt < CW'(2)) begin
                  code_nxt  = E_UNF;
                  skip_nxt  = !in_last;
                  state_nxt = S_FLUSH;
                end else begin
                  q_opcode = OP_PAIR;
                  q_back   = in_data[0] ? diff : sum;
                  cnt_nxt  = cnt - 1'b1;
                end
              end
`ifdef QUEUE_CALC_MUL_EN
              2'd2: begin
                if (cnt < CW'(2)) begin
                  code_nxt  = E_UNF;
                  skip_nxt  = !in_last;
                  state_nxt = S_FLUSH;
                end else begin
                  mul_nxt   = entry0 * entry1;
                  last_nxt  = in_last;
                  state_nxt = S_MULW;
                end
              end
`endif
              default: begin
                code_nxt  = E_BADOP;
                skip_nxt  = !in_last;
                state_nxt = S_FLUSH;
              end
            endcase
          end
          // End-of-expression check only for tokens that completed normally.
          if (in_last && state_nxt == S_RUN) begin
            if (cnt_nxt == CW'(1)) begin
              state_nxt = S_RESULT;
            end else begin
              code_nxt  = E_END;
              skip_nxt  = 1'b0;
              state_nxt = S_FLUSH;
            end
          end
        end
      end
`ifdef QUEUE_CALC_MUL_EN
      S_MULW: begin
        q_opcode  = OP_PAIR;
        q_back    = mul_q;
        cnt_nxt   = cnt - 1'b1;
        state_nxt = S_RUN;
        if (last_q) begin
          if (cnt_nxt == CW'(1)) begin
            state_nxt = S_RESULT;
          end else begin
            code_nxt  = E_END;
            skip_nxt  = 1'b0;
            state_nxt = S_FLUSH;
          end
        end
      end
`endif
      S_RESULT: begin
        res_valid = 1'b1;
        res_data  = entry0;
        if (res_ready) begin
          q_opcode  = OP_POP;
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        if (cnt != '0) begin
          q_opcode = OP_POP;
          cnt_nxt  = cnt - 1'b1;
        end else begin
          state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        res_valid = 1'b1;
        res_err   = 1'b1;
        res_code  = code;
        if (res_ready) begin
          state_nxt = skip ? S_SKIP : S_RUN;
        end
      end
      S_SKIP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase

    // Quiet all outputs while reset is asserted.
    if (!rst) begin
      in_ready  = 1'b0;
      q_opcode  = OP_HOLD;
      q_back    = '0;
      res_valid = 1'b0;
      res_data  = '0;
      res_err   = 1'b0;
      res_code  = E_NONE;
    end
  end

endmodule

// File: tb/tb_queue_calc_ctrl.sv
// Directed bench for queue_calc_ctrl with a behavioural model of the queue.
// Build with QUEUE_CALC_MUL_EN defined to exercise the MUL path.
module tb_queue_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_op = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic [1:0]  q_opcode;
  logic [7:0]  q_back;
  logic [15:0] q_top = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_data;
  logic        res_err;
  logic [2:0]  res_code;

  int n_tests = 0;
  int n_fail  = 0;

  queue_calc_ctrl #(.DEPTH(5), .W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_op(in_is_op),
    .in_data(in_data), .in_last(in_last),
    .q_opcode(q_opcode), .q_back(q_back), .q_top(q_top),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_code(res_code)
  );

  always #5 clk = ~clk;

  // Queue model: command captured mid-cycle, applied just after the edge.
  logic [7:0] qm[$];
  logic [1:0] cap_op = 2'b01;
  logic [7:0] cap_back = '0;

  always @(negedge clk) begin
    cap_op   = q_opcode;
    cap_back = q_back;
  end

  always begin
    logic rs;
    @(posedge clk);
    rs = rst;
    #1;
    if (!rs) begin
      qm.delete();
    end else begin
      case (cap_op)
        2'b00: qm.push_back(cap_back);
        2'b10: begin
          if (qm.size() > 0) void'(qm.pop_front());
          if (qm.size() > 0) void'(qm.pop_front());
          qm.push_back(cap_back);
        end
        2'b11: if (qm.size() > 0) void'(qm.pop_front());
        default: ;
      endcase
    end
    q_top = {(qm.size() > 0) ? qm[0] : 8'd0, (qm.size() > 1) ? qm[1] : 8'd0};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Offer one token for one cycle; returns the queue command seen with it.
  task automatic send(input logic is_op, input logic [7:0] d, input logic last,
                      output logic [1:0] op);
    in_valid = 1'b1; in_is_op = is_op; in_data = d; in_last = last;
    @(negedge clk);
    op = q_opcode;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_is_op = 1'b0; in_data = '0; in_last = 1'b0;
  endtask

  // Wait for res_valid, counting pop-front commands on the way.
  task automatic wait_res(input string tag, output int pops);
    bit got = 1'b0;
    pops = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
      else if (q_opcode == 2'b11) pops++;
    end
    chk({tag, "_res_valid"}, 32'(got), 1);
  endtask

  task automatic ack(output logic [1:0] op);
    res_ready = 1'b1;
    #1;
    op = q_opcode;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic expr3(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] opr, input logic [7:0] expv);
    logic [1:0] o1, o2, o3, oa;
    int p;
    send(1'b0, a, 1'b0, o1);
    send(1'b0, b, 1'b0, o2);
    send(1'b1, opr, 1'b1, o3);
    chk({tag, "_op_seq"}, {o1, o2, o3}, {2'b00, 2'b00, 2'b10});
    wait_res(tag, p);
    chk({tag, "_data"}, res_data, expv);
    chk({tag, "_err"}, {res_err, res_code}, 0);
    ack(oa);
    chk({tag, "_ack_op"}, oa, 2'b11);
    @(negedge clk);
    chk({tag, "_q_empty"}, qm.size(), 0);
    chk({tag, "_valid_low"}, res_valid, 0);
  endtask

  initial begin
    logic [1:0] o, oa;
    int p;

    // Reset behaviour.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {in_ready, res_valid, res_err, res_data, q_opcode, q_back},
        {1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 8'd0});
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst", {res_valid, q_opcode, in_ready}, {1'b0, 2'b01, 1'b1});
    @(posedge clk); #1;

    // Basic arithmetic.
    expr3("add_3_4", 8'd3, 8'd4, 8'd0, 8'd7);
    @(posedge clk); #1;
    expr3("sub_wrap", 8'd3, 8'd10, 8'd1, 8'd249);
    @(posedge clk); #1;
    expr3("sub_10_3", 8'd10, 8'd3, 8'd1, 8'd7);
    @(posedge clk); #1;

    // Overflow: sixth operand into a five-entry queue.
    for (int i = 1; i <= 5; i++) send(1'b0, 8'(i), 1'b0, o);
    send(1'b0, 8'd6, 1'b0, o);
    chk("ovf_no_push", o, 2'b01);
    wait_res("ovf", p);
    chk("ovf_pops", p, 5);
    chk("ovf_report", {res_err, res_code, res_data}, {1'b1, 3'd1, 8'd0});
    ack(oa);
    send(1'b0, 8'd9, 1'b0, o);
    chk("skip_drop1", o, 2'b01);
    send(1'b1, 8'd0, 1'b1, o);
    chk("skip_drop2", o, 2'b01);
    @(negedge clk);
    chk("skip_q_empty", qm.size(), 0);
    @(posedge clk); #1;
    expr3("after_skip", 8'd1, 8'd2, 8'd0, 8'd3);
    @(posedge clk); #1;

    // Underflow: operator with one entry.
    send(1'b0, 8'd5, 1'b0, o);
    send(1'b1, 8'd0, 1'b0, o);
    chk("unf_no_op", o, 2'b01);
    wait_res("unf", p);
    chk("unf_pops", p, 1);
    chk("unf_report", {res_err, res_code, res_data}, {1'b1, 3'd2, 8'd0});
    ack(oa);
    send(1'b0, 8'd0, 1'b1, o);

    // Bad end with held handshake.
    send(1'b0, 8'd5, 1'b0, o);
    send(1'b0, 8'd6, 1'b1, o);
    chk("bad_end_push", o, 2'b00);
    wait_res("bad_end", p);
    chk("bad_end_pops", p, 2);
    chk("bad_end_report", {res_err, res_code, res_data}, {1'b1, 3'd4, 8'd0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_stable", {res_valid, res_err, res_code, res_data}, {1'b1, 1'b1, 3'd4, 8'd0});
    end
    ack(oa);

    // MUL.
    send(1'b0, 8'd20, 1'b0, o);
    send(1'b0, 8'd13, 1'b0, o);
    send(1'b1, 8'd2, 1'b1, o);
    chk("mul_accept_op", o, 2'b01);
`ifdef QUEUE_CALC_MUL_EN
    @(negedge clk);
    chk("mulw_cycle", {in_ready, q_opcode, q_back}, {1'b0, 2'b10, 8'd4});
    wait_res("mul", p);
    chk("mul_result", {res_err, res_data}, {1'b0, 8'd4});
    ack(oa);
    chk("mul_ack_op", oa, 2'b11);
`else
    wait_res("mul_off", p);
    chk("mul_off_pops", p, 2);
    chk("mul_off_report", {res_err, res_code, res_data}, {1'b1, 3'd3, 8'd0});
    ack(oa);
`endif
    @(negedge clk);
    chk("mul_q_empty", qm.size(), 0);
    @(posedge clk); #1;

    // Reset during FLUSH.
    send(1'b0, 8'd1, 1'b0, o);
    send(1'b0, 8'd2, 1'b1, o);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_out", {in_ready, res_valid, q_opcode, q_back}, {1'b0, 1'b0, 2'b01, 8'd0});
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_flush_after", {in_ready, res_valid, q_opcode}, {1'b1, 1'b0, 2'b01});
    chk("rst_flush_cnt", 32'(dut.cnt), 0);
    @(posedge clk); #1;
    expr3("after_rst", 8'd10, 8'd3, 8'd1, 8'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
